// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Single-port 32 x 32-bit data memory that answers one request at a time from
// the pipeline MEM stage. A request is accepted only from IDLE; its address,
// direction and write data are latched at acceptance. The access completes with
// a one-cycle ready strobe (state DONE). DONE always returns to IDLE, so
// back-to-back requests are separated by one IDLE cycle.
//
// Optional feature (macro DATA_MEM_WAIT_STATE_EN):
//   defined   -> WAIT_CYCLES wait states are inserted in state BUSY before the
//                access; ready rises WAIT_CYCLES+1 edges after acceptance
//                (counting the acceptance edge).
//   undefined -> BUSY is never entered; the access happens at the acceptance
//                edge and WAIT_CYCLES is ignored (range-checked only).
//
// Parameters:
//   WAIT_CYCLES  wait states per access when the macro is defined (0..15)
//
// Ports:
//   Clock   in   1   system clock, rising edge
//   Resetn  in   1   asynchronous active-low reset (clears state AND memory)
//   req     in   1   access request
//   we      in   1   1 = write, 0 = read (qualified by req)
//   addr    in   5   word address
//   wdata   in   32  write data
//   rdata   out  32  registered read data (not changed by writes)
//   ready   out  1   completion strobe, high exactly while in DONE
//   stall   out  1   combinational hold: BUSY, or IDLE with req pending
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        req,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        stall
);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_range
        $error("data_mem_responder: WAIT_CYCLES must be in 0..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] mem [32];

    // Request fields captured at acceptance
    logic        we_p0;
    logic [4:0]  addr_p0;
    logic [31:0] wdata_p0;

`ifdef DATA_MEM_WAIT_STATE_EN
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
    logic [3:0] wait_cnt;
`endif

    // An access performed at the acceptance edge must use the live inputs
    // (the latch is being written at that same edge); an access performed from
    // BUSY uses the latched copy so input changes in BUSY are ignored.
    logic        acc_we;
    logic [4:0]  acc_addr;
    logic [31:0] acc_wdata;

    always_comb begin
        acc_we    = we_p0;
        acc_addr  = addr_p0;
        acc_wdata = wdata_p0;
        if (state == IDLE) begin
            acc_we    = we;
            acc_addr  = addr;
            acc_wdata = wdata;
        end
    end

    assign stall = (state == BUSY) || ((state == IDLE) && req);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state    <= IDLE;
            rdata    <= '0;
            ready    <= 1'b0;
            we_p0    <= 1'b0;
            addr_p0  <= '0;
            wdata_p0 <= '0;
`ifdef DATA_MEM_WAIT_STATE_EN
            wait_cnt <= '0;
`endif
            for (int i = 0; i < 32; i++) begin
                mem[i] <= '0;
            end
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_p0    <= we;
                        addr_p0  <= addr;
                        wdata_p0 <= wdata;
`ifdef DATA_MEM_WAIT_STATE_EN
                        if (WAIT_CYCLES > 0) begin
                            wait_cnt <= WAIT_LOAD;
                            state    <= BUSY;
                        end else begin
                            if (acc_we) mem[acc_addr] <= acc_wdata;
                            else        rdata         <= mem[acc_addr];
                            ready <= 1'b1;
                            state <= DONE;
                        end
`else
                        if (acc_we) mem[acc_addr] <= acc_wdata;
                        else        rdata         <= mem[acc_addr];
                        ready <= 1'b1;
                        state <= DONE;
`endif
                    end
                end
`ifdef DATA_MEM_WAIT_STATE_EN
                BUSY: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        if (acc_we) mem[acc_addr] <= acc_wdata;
                        else        rdata         <= mem[acc_addr];
                        ready <= 1'b1;
                        state <= DONE;
                    end
                end
`endif
                // DONE never accepts a new request; it always yields one IDLE cycle.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Directed bench for data_mem_responder. The driver issues requests and pushes
// the hand-computed expected rdata and ready cycle into a scoreboard queue; an
// independent monitor pops and compares on every ready strobe. The driver also
// checks stall and reset values at fixed points of each access.
// Works for both builds of DATA_MEM_WAIT_STATE_EN (WAIT_CYCLES = 2 when defined).
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

`ifdef DATA_MEM_WAIT_STATE_EN
    localparam int W_EFF = 2;
`else
    localparam int W_EFF = 0;
`endif

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        stall;

    data_mem_responder #(.WAIT_CYCLES(2)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .ready  (ready),
        .stall  (stall)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rd;
        int          rdy_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   pushed   = 0;
    int   seen     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req_v);
        end
    endtask

    // Monitor: every ready strobe must match the oldest outstanding expectation.
    always @(negedge Clock) begin
        if (Resetn && ready) begin
            seen++;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready actual=1 required=0 cycle=%0d", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("rdata", rdata, e.rd);
                chk("ready_cycle", 32'(cyc), 32'(e.rdy_cyc));
            end
        end
    end

    // Issue one access starting at a negedge with the DUT in IDLE; returns at the
    // negedge where the DUT is back in IDLE. With keep_req the request stays
    // asserted through DONE (it must not be taken there).
    task automatic issue(input logic w, input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input bit keep_req);
        exp_t e;
        req = 1'b1; we = w; addr = a; wdata = d;
        #1 chk("stall_idle_req", 32'(stall), 32'd1);
        @(posedge Clock); #1;
        e.rd = exp_rd;
        e.rdy_cyc = cyc + W_EFF;
        sb_q.push_back(e);
        pushed++;
        if (!keep_req) begin
            // Garbage on the inputs after acceptance must be ignored.
            req = 1'b0; we = ~w; addr = a ^ 5'b01110; wdata = ~d;
        end
        for (int k = 0; k <= W_EFF; k++) begin
            @(negedge Clock);
            chk(k < W_EFF ? "stall_busy" : "stall_done", 32'(stall), (k < W_EFF) ? 32'd1 : 32'd0);
        end
        @(negedge Clock);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(negedge Clock);
        @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);

        issue(1'b1, 5'd5,  32'hDEADBEEF, 32'h0,        1'b0);
        issue(1'b0, 5'd5,  32'h0,        32'hDEADBEEF, 1'b0);
        issue(1'b0, 5'd6,  32'h0,        32'h0,        1'b0);
        issue(1'b1, 5'd31, 32'h12345678, 32'h0,        1'b0);
        issue(1'b0, 5'd31, 32'h0,        32'h12345678, 1'b0);

        // Write to 7; inputs move to addr 9 right after acceptance
        issue(1'b1, 5'd7,  32'hCAFEF00D, 32'h12345678, 1'b0);
        issue(1'b0, 5'd7,  32'h0,        32'hCAFEF00D, 1'b0);
        issue(1'b0, 5'd9,  32'h0,        32'h0,        1'b0);

        // req held high across three accesses
        issue(1'b1, 5'd10, 32'h01010101, 32'h0,        1'b1);
        issue(1'b1, 5'd11, 32'h02020202, 32'h0,        1'b1);
        issue(1'b0, 5'd10, 32'h0,        32'h01010101, 1'b0);
        issue(1'b0, 5'd11, 32'h0,        32'h02020202, 1'b0);

        // Reset right after accepting a write to 3: no ready, memory cleared
        req = 1'b1; we = 1'b1; addr = 5'd3; wdata = 32'hAAAA5555;
        @(posedge Clock); #1;
        req = 1'b0;
        Resetn = 1'b0;
        #2;
        chk("rst_mid_ready", 32'(ready), 32'd0);
        chk("rst_mid_rdata", rdata, 32'd0);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);
        chk("post_rst_ready", 32'(ready), 32'd0);

        issue(1'b0, 5'd3,  32'h0,        32'h0,        1'b0);
        issue(1'b0, 5'd5,  32'h0,        32'h0,        1'b0);
        issue(1'b1, 5'd3,  32'h5A5A5A5A, 32'h0,        1'b0);
        issue(1'b0, 5'd3,  32'h0,        32'h5A5A5A5A, 1'b0);

        repeat (4) @(negedge Clock);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        chk("ready_count", 32'(seen), 32'(pushed));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, giving the number of wait-state cycles per access when DATA_MEM_WAIT_STATE_EN is defined; legal range 0..15.
REQ-002 SHALL have port Clock  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port Resetn  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port req  input  1  access request from the pipeline MEM stage.
REQ-005 SHALL have port we  input  1  1 = write, 0 = read; qualified by req.
REQ-006 SHALL have port addr  input  5  word address (32 words).
REQ-007 SHALL have port wdata  input  32  write data.
REQ-008 SHALL have port rdata  output  32  registered read data.
REQ-009 SHALL have port ready  output  1  one-cycle completion strobe.
REQ-010 SHALL have port stall  output  1  combinational pipeline-hold request.

Function
REQ-011 SHALL contain 32 x 32-bit storage words and a 3-state FSM: IDLE, BUSY, DONE.
REQ-012 In IDLE, req=1 at a rising edge SHALL be accepted: addr, we, wdata latched; req=0 keeps IDLE.
REQ-013 On acceptance with WAIT_CYCLES>0 (macro defined): next state BUSY, wait counter loaded with WAIT_CYCLES-1.
REQ-014 In BUSY, each edge: counter nonzero -> decrement; counter zero -> perform access, go DONE.
REQ-015 On acceptance with WAIT_CYCLES=0 or macro undefined: perform access at the same edge, go DONE.
REQ-016 Access: write stores latched wdata at latched addr; read loads rdata from latched addr; rdata unchanged by writes.
REQ-017 ready SHALL be 1 exactly while state=DONE; DONE always returns to IDLE at the next edge.
REQ-018 req seen in DONE SHALL NOT be accepted; it is accepted from IDLE one cycle later (no back-to-back overlap).
REQ-019 Inputs changing during BUSY/DONE SHALL be ignored; only latched values are used.
REQ-020 stall = (state=BUSY) OR (state=IDLE AND req=1); stall=0 in DONE.
REQ-021 Latency: acceptance edge to ready high = WAIT_CYCLES+1 edges (macro defined), 1 edge (undefined).
REQ-022 A read of an address written earlier SHALL return the last written value; unwritten words read 0.

Reset
REQ-023 Resetn=0 SHALL immediately force state=IDLE, counter=0, rdata=0, ready=0, all 32 words=0, latched fields=0.
REQ-024 Reset during BUSY SHALL abort the access: no write performed, no ready strobe.
REQ-025 After Resetn deasserts, the first edge with req=1 SHALL be accepted normally.

Configuration
REQ-026 Macro DATA_MEM_WAIT_STATE_EN defined: BUSY state and counter present, latency per REQ-013/014.
REQ-027 Macro undefined: BUSY unreachable/removed, every access completes per REQ-015, WAIT_CYCLES ignored.

Verification
REQ-028 Macro defined, WAIT_CYCLES=2: write addr=5 wdata=0xDEADBEEF -> stall high 3 cycles, ready high on 3rd edge after acceptance, word 5 = 0xDEADBEEF.
REQ-029 Macro defined, WAIT_CYCLES=2: read addr=5 after REQ-028 -> rdata=0xDEADBEEF while ready=1; read addr=6 -> rdata=0.
REQ-030 Macro undefined: write addr=31 wdata=0x12345678 then read addr=31 -> each ready 1 edge after acceptance, rdata=0x12345678, stall only in IDLE-with-req cycles.
REQ-031 req held high continuously for 3 accesses -> ready pulses separated by one IDLE cycle each; no request lost or duplicated.
REQ-032 Write addr=3 wdata=0xAAAA5555, Resetn pulsed low during BUSY -> no ready, word 3 reads 0 after reset.
REQ-033 Change addr/wdata during BUSY (addr 7->9) -> access uses addr 7 only; word 9 unchanged.
